cw_trace_buffer: RTL and testbench

//  Sample store directly downstream of the ChipWatcher core (cwc_top): accepts wt_ce/wt_en/wt_addr

---
 rtl/cw_trace_pkg.sv | 14 +
 rtl/cw_trace_ram.sv | 32 +++
 rtl/cw_trace_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_cw_trace_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_trace_pkg.sv
// Shared definitions for the ChipWatcher trace buffer: FSM state encoding
// and the fixed read-pipeline latency.
package cw_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // rd_req to rd_valid distance: one cycle for the RAM read, one for the output register.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/cw_trace_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port.
// No reset on the array or the read register so it maps onto block RAM.
module cw_trace_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 5461,
  parameter int AW     = 13
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Callers only assert we_i/re_i with in-range addresses.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cw_trace_buffer.sv
// Trace sample store behind cwc_top: aligns the probe bus with the write strobes,
// records samples into RAM during capture, and serves host reads once capture is done.
module cw_trace_buffer
  import cw_trace_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 5461,
  parameter int DIN_DLY = 1
) (
  input  logic              trig_clk,
  input  logic              trig_rst,
  input  logic [DATA_W-1:0] bus_din,
  input  logic              wt_ce,
  input  logic              wt_en,
  input  logic [ADDR_W-1:0] wt_addr,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] wr_count,
  output logic [ADDR_W-1:0] last_addr,
  output logic              overflow,
  output logic              done,
  output logic [1:0]        dbg_state_o
);

  localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Probe delay line: bus_din is DIN_DLY cycles ahead of the matching wt_* strobe.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] wr_din;

  generate
    if (DIN_DLY == 0) begin : g_no_dly
      assign wr_din = bus_din;
    end else begin : g_dly
      logic [DATA_W-1:0] dly_q [DIN_DLY];

      always_ff @(posedge trig_clk or posedge trig_rst) begin
        if (trig_rst) begin
          for (int i = 0; i < DIN_DLY; i++) begin
            dly_q[i] <= '0;
          end
        end else begin
          dly_q[0] <= bus_din;
          for (int i = 1; i < DIN_DLY; i++) begin
            dly_q[i] <= dly_q[i-1];
          end
        end
      end

      assign wr_din = dly_q[DIN_DLY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   wr_try;
  logic   wr_in_rng;
  logic   wr_acc;
  logic   wr_ovf;

  assign wr_in_rng = (wt_addr < DEPTH_A);

  always_comb begin
    state_d = state_q;
    wr_try  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_try = wt_ce & wt_en;
        if (wr_try) begin
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        wr_try = wt_ce & wt_en;
        if (!wt_ce) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // clr beats any concurrent write and forces IDLE from every state.
    if (clr) begin
      state_d = ST_IDLE;
      wr_try  = 1'b0;
    end
  end

  assign wr_acc = wr_try & wr_in_rng;
  assign wr_ovf = wr_try & ~wr_in_rng;

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture statistics
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              overflow_q, overflow_d;

  always_comb begin
    wr_count_d  = wr_count_q;
    last_addr_d = last_addr_q;
    overflow_d  = overflow_q;
    if (clr) begin
      wr_count_d  = '0;
      last_addr_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_count_q < DEPTH_A) begin
          wr_count_d = wr_count_q + ADDR_W'(1);
        end
        last_addr_d = wt_addr;
      end
      if (wr_ovf) begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      wr_count_q  <= '0;
      last_addr_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_count_q  <= wr_count_d;
      last_addr_q <= last_addr_d;
      overflow_q  <= overflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline. Handshake: rd_req is a one-cycle request with rd_addr sampled
  // alongside it; exactly RD_LAT cycles later rd_valid pulses for one cycle with
  // rd_data/rd_err. There is no ready/backpressure, so one request per cycle is
  // always accepted and responses come back in request order.
  // ---------------------------------------------------------------------------
  logic              rd_err_now;
  logic              rd_en;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_data_q;

  assign rd_err_now = (state_q != ST_DONE) | (rd_addr >= DEPTH_A);
  assign rd_en      = rd_req & ~rd_err_now;

  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      vld_q     <= '0;
      err_q     <= '0;
      rd_data_q <= '0;
    end else begin
      vld_q     <= {vld_q[RD_LAT-2:0], rd_req};
      err_q     <= {err_q[RD_LAT-2:0], rd_req & rd_err_now};
      rd_data_q <= (vld_q[0] & ~err_q[0]) ? ram_rdata : '0;
    end
  end

  cw_trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk_i   (trig_clk),
    .we_i    (wr_acc),
    .waddr_i (wt_addr[RAM_AW-1:0]),
    .wdata_i (wr_din),
    .re_i    (rd_en),
    .raddr_i (rd_addr[RAM_AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd_valid    = vld_q[RD_LAT-1];
  assign rd_err      = err_q[RD_LAT-1];
  assign rd_data     = rd_data_q;
  assign wr_count    = wr_count_q;
  assign last_addr   = last_addr_q;
  assign overflow    = overflow_q;
  assign done        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cw_trace_buffer.sv
// Self-checking bench for cw_trace_buffer: directed scenarios plus a randomized phase,
// all outputs compared every cycle against a behavioural model.
module tb_cw_trace_buffer;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 16;
  localparam int DEPTH   = 5461;
  localparam int DIN_DLY = 1;

  // ---------------- clock / reset / DUT ----------------
  logic              trig_clk = 1'b0;
  logic              trig_rst;
  logic [DATA_W-1:0] bus_din;
  logic              wt_ce;
  logic              wt_en;
  logic [ADDR_W-1:0] wt_addr;
  logic              clr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic [ADDR_W-1:0] wr_count;
  logic [ADDR_W-1:0] last_addr;
  logic              overflow;
  logic              done;
  logic [1:0]        dbg_state_o;

  always #5 trig_clk = ~trig_clk;

  cw_trace_buffer #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .DIN_DLY (DIN_DLY)
  ) dut (
    .trig_clk    (trig_clk),
    .trig_rst    (trig_rst),
    .bus_din     (bus_din),
    .wt_ce       (wt_ce),
    .wt_en       (wt_en),
    .wt_addr     (wt_addr),
    .clr         (clr),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .wr_count    (wr_count),
    .last_addr   (last_addr),
    .overflow    (overflow),
    .done        (done),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- reference model ----------------
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  bit  m_capt, m_done, m_ovf;
  int  m_cnt, m_last;
  logic [DATA_W-1:0] m_mem [int];
  logic [DATA_W-1:0] hist [$];
  logic [DATA_W:0]   exp_q [$];
  int                due_q [$];
  bit                known_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_capt = 0; m_done = 0; m_ovf = 0; m_cnt = 0; m_last = 0;
    hist.delete();
    repeat (DIN_DLY) hist.push_back('0);
    exp_q.delete(); due_q.delete(); known_q.delete();
  endtask

  function automatic int exp_state();
    return m_done ? 2 : (m_capt ? 1 : 0);
  endfunction

  task automatic check_outputs();
    logic [DATA_W:0] e;
    bit k;
    check("wr_count", wr_count, m_cnt);
    check("last_addr", last_addr, m_last);
    check("overflow", overflow, m_ovf);
    check("done", done, m_done);
    check("state", dbg_state_o, exp_state());
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      e = exp_q.pop_front();
      k = known_q.pop_front();
      void'(due_q.pop_front());
      check("rd_valid", rd_valid, 1);
      check("rd_err", rd_err, e[DATA_W]);
      if (k) check("rd_data", rd_data, e[DATA_W-1:0]);
    end else begin
      check("rd_valid_idle", rd_valid, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_err"}, rd_err, 0);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_last_addr"}, last_addr, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  // One clock: apply the rules to the inputs present before the edge, then compare.
  task automatic cycle();
    logic [DATA_W-1:0] d;
    bit err;
    d = (hist.size() == 0) ? bus_din : hist[hist.size()-1];
    if (rd_req) begin
      err = !m_done || (int'(rd_addr) >= DEPTH);
      if (err) begin
        exp_q.push_back({1'b1, {DATA_W{1'b0}}}); known_q.push_back(1);
      end else if (m_mem.exists(int'(rd_addr))) begin
        exp_q.push_back({1'b0, m_mem[int'(rd_addr)]}); known_q.push_back(1);
      end else begin
        exp_q.push_back('0); known_q.push_back(0);
      end
      due_q.push_back(cyc + 2);
    end
    if (clr) begin
      m_capt = 0; m_done = 0; m_cnt = 0; m_last = 0; m_ovf = 0;
    end else if (!m_done) begin
      if (m_capt && !wt_ce) begin
        m_done = 1;
      end else if (wt_ce && wt_en) begin
        m_capt = 1;
        if (int'(wt_addr) < DEPTH) begin
          m_mem[int'(wt_addr)] = d;
          if (m_cnt < DEPTH) m_cnt++;
          m_last = int'(wt_addr);
        end else begin
          m_ovf = 1;
        end
      end
    end
    hist.push_front(bus_din);
    if (hist.size() > DIN_DLY) void'(hist.pop_back());
    @(posedge trig_clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input int addr, input int din);
    wt_ce = 1; wt_en = 1; wt_addr = ADDR_W'(addr); bus_din = DATA_W'(din);
    cycle();
    wt_en = 0;
  endtask

  // Presents the data one cycle ahead so it lands with the strobe (DIN_DLY=1).
  task automatic wr_aligned(input int addr, input int din);
    wt_ce = 1; wt_en = 0; bus_din = DATA_W'(din);
    cycle();
    wr(addr, din);
  endtask

  task automatic rd(input int addr);
    rd_req = 1; rd_addr = ADDR_W'(addr);
    cycle();
    rd_req = 0;
  endtask

  task automatic end_capture();
    wt_ce = 0; wt_en = 0;
    cycle();
  endtask

  task automatic pulse_clr();
    clr = 1;
    cycle();
    clr = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nv;
    trig_rst = 1; bus_din = '0; wt_ce = 0; wt_en = 0; wt_addr = '0;
    clr = 0; rd_req = 0; rd_addr = '0;
    #1;
    check_all_zero("reset");
    model_reset();
    @(posedge trig_clk);
    #1;
    trig_rst = 0;
    cycle();

    // 1: eight samples, capture end, read back addr 3
    wt_ce = 1; wt_en = 0; bus_din = 4'h1;
    cycle();
    for (int i = 0; i < 8; i++) wr(i, i + 2);
    end_capture();
    check("t1_done", done, 1);
    check("t1_count", wr_count, 8);
    check("t1_last", last_addr, 7);
    rd(3);
    check("t1_rd_lat1", rd_valid, 0);
    cycle();
    check("t1_rd_valid", rd_valid, 1);
    check("t1_rd_data", rd_data, 4);
    check("t1_rd_err", rd_err, 0);

    // 2: out-of-range write, then out-of-range read in DONE
    pulse_clr();
    wr(0, 5);
    wr(DEPTH, 4'hf);
    check("t2_ovf", overflow, 1);
    check("t2_count", wr_count, 1);
    check("t2_last", last_addr, 0);
    end_capture();
    rd(DEPTH);
    cycle();
    check("t2_rd_err", rd_err, 1);
    check("t2_rd_data", rd_data, 0);

    // 3: read while capturing is rejected
    pulse_clr();
    wr(10, 3);
    rd(20);
    cycle();
    check("t3_rd_valid", rd_valid, 1);
    check("t3_rd_err", rd_err, 1);
    check("t3_rd_data", rd_data, 0);

    // 4: clr coincident with a write drops that write
    wr_aligned(100, 4'ha);
    end_capture();
    pulse_clr();
    wr_aligned(50, 4'h3);
    bus_din = 4'h5; wt_ce = 1;
    cycle();
    clr = 1; wt_en = 1; wt_addr = 16'd100;
    cycle();
    clr = 0; wt_en = 0;
    check("t4_state_idle", dbg_state_o, 0);
    check("t4_count", wr_count, 0);
    wr_aligned(60, 4'h6);
    check("t4_restart", dbg_state_o, 1);
    end_capture();
    rd(100);
    cycle();
    check("t4_ram_kept", rd_data, 4'ha);

    // 5: saturation and back-to-back reads
    pulse_clr();
    for (int i = 0; i < 6000; i++) wr(i % DEPTH, $urandom_range(0, 15));
    check("t5_sat", wr_count, DEPTH);
    end_capture();
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1; rd_addr = ADDR_W'(i);
      cycle();
      if (rd_valid) nv++;
    end
    rd_req = 0;
    repeat (3) begin
      cycle();
      if (rd_valid) nv++;
    end
    check("t5_valid_run", nv, 4);

    // randomized phase
    pulse_clr();
    for (int n = 0; n < 1500; n++) begin
      bus_din = DATA_W'($urandom_range(0, 15));
      wt_ce   = ($urandom_range(0, 15) != 0);
      wt_en   = ($urandom_range(0, 1) == 1);
      wt_addr = ($urandom_range(0, 9) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 100))
                                            : ADDR_W'($urandom_range(0, 63));
      rd_req  = ($urandom_range(0, 2) == 0);
      rd_addr = ($urandom_range(0, 9) == 0) ? ADDR_W'(DEPTH + $urandom_range(0, 100))
                                            : ADDR_W'($urandom_range(0, 63));
      clr     = ($urandom_range(0, 40) == 0);
      cycle();
    end
    clr = 0; rd_req = 0; wt_en = 0;
    repeat (3) cycle();

    // 6: reset mid-capture with reads in flight
    pulse_clr();
    wr(5, 1);
    rd_req = 1; rd_addr = 16'd7;
    cycle();
    rd_addr = 16'd8;
    cycle();
    rd_req = 0;
    check("t6_pre_valid", rd_valid, 1);
    trig_rst = 1;
    #1;
    check_all_zero("t6_rst");
    model_reset();
    @(posedge trig_clk);
    #1;
    trig_rst = 0; wt_ce = 0; wt_en = 0;
    check_all_zero("t6_rel");
    cycle();
    cycle();
    check("t6_state", dbg_state_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
